ntcrack_host_driver: RTL and testbench

Host-side driver for the cracker's byte-wise control port. It takes a framed byte stream from the host link (UART receiver side), loads the target hashes into the cracker through the `store_hash_byte` handshake, and starts the search with `go`. When the cracker reports, it collects the result byte by byte and returns a framed response to the host link (UART transmitter side).

---
 rtl/ntcrack_host_driver.sv | 174 +++++++++++++++++
 tb/tb_ntcrack_host_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntcrack_host_driver.sv
// ntcrack_host_driver: takes a framed hash list from the host, loads it into
// the cracker one byte per cracker handshake, starts the search, then returns
// a framed result (0x00 = exhausted, 0x01 + length + password chars = match,
// 0xEE = bad hash count) to the host.
module ntcrack_host_driver #(
  parameter int NUM_HASHES = 128,
  parameter int HASH_BYTES = 16,
  parameter int MAX_PW_LEN = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] new_hash_byte,
  output logic       store_hash_byte,
  output logic       go,
  input  logic       your_turn,
  input  logic       match_found,
  input  logic [7:0] password_byte
);

  localparam int CNT_W = 12;
  localparam logic [8:0]       MAX_N      = 9'(NUM_HASHES);
  localparam logic [CNT_W-1:0] BYTES_PER  = CNT_W'(HASH_BYTES);
  localparam logic [7:0]       MAX_LEN    = 8'(MAX_PW_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_PWLEN,
    S_PWCHAR,
    S_ERR
  } state_t;

  state_t           state;
  logic             wait_low;     // strobe issued, waiting for your_turn to drop
  logic             armed;        // low only in the cycle right after reset
  logic             adv_pending;  // a go advance is owed once the out byte is gone
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] byte_total;
  logic [7:0]       pw_len;

  logic             turn_ok;
  logic             accept;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       len_clamped;

  // Cracker handshake window and host-side acceptance
  assign turn_ok     = your_turn && !wait_low;
  assign in_ready    = armed && !out_valid &&
                       ((state == S_IDLE) || ((state == S_LOAD) && turn_ok));
  assign accept      = in_valid && in_ready;
  assign cnt_next    = byte_cnt + 1'b1;
  assign len_clamped = (password_byte > MAX_LEN) ? MAX_LEN : password_byte;

  // Main control FSM with registered strobes and host response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      wait_low        <= 1'b0;
      armed           <= 1'b0;
      adv_pending     <= 1'b0;
      byte_cnt        <= '0;
      byte_total      <= '0;
      pw_len          <= '0;
      out_byte        <= 8'h00;
      out_valid       <= 1'b0;
      new_hash_byte   <= 8'h00;
      store_hash_byte <= 1'b0;
      go              <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so any set below lasts exactly
      // one clock; all state uses non-blocking assignments so every branch
      // sees the pre-edge values.
      store_hash_byte <= 1'b0;
      go              <= 1'b0;
      armed           <= 1'b1;
      if (!your_turn) wait_low <= 1'b0;

      if (out_valid) begin
        // Stall until the host consumes the byte; advance right away if owed.
        if (out_ready) begin
          out_valid <= 1'b0;
          if (adv_pending && turn_ok) begin
            go          <= 1'b1;
            wait_low    <= 1'b1;
            adv_pending <= 1'b0;
          end
        end
      end else if (adv_pending) begin
        if (turn_ok) begin
          go          <= 1'b1;
          wait_low    <= 1'b1;
          adv_pending <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (in_byte == 8'h00 || {1'b0, in_byte} > MAX_N) begin
                state <= S_ERR;
              end else begin
                byte_total <= CNT_W'(in_byte) * BYTES_PER;
                byte_cnt   <= '0;
                state      <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            if (accept) begin
              new_hash_byte   <= in_byte;
              store_hash_byte <= 1'b1;
              wait_low        <= 1'b1;
              byte_cnt        <= cnt_next;
              if (cnt_next == byte_total) state <= S_START;
            end
          end
          S_START: begin
            if (turn_ok) begin
              go       <= 1'b1;
              wait_low <= 1'b1;
              state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (turn_ok) begin
              out_valid <= 1'b1;
              if (match_found) begin
                out_byte <= 8'h01;
                state    <= S_PWLEN;
              end else begin
                out_byte <= 8'h00;
                state    <= S_IDLE;
              end
            end
          end
          S_PWLEN: begin
            pw_len    <= len_clamped;
            out_byte  <= len_clamped;
            out_valid <= 1'b1;
            if (len_clamped == 8'h00) begin
              state <= S_IDLE;
            end else begin
              adv_pending <= 1'b1;
              state       <= S_PWCHAR;
            end
          end
          S_PWCHAR: begin
            if (turn_ok) begin
              out_byte  <= password_byte;
              out_valid <= 1'b1;
              pw_len    <= pw_len - 1'b1;
              if (pw_len == 8'h01) state <= S_IDLE;
              else                 adv_pending <= 1'b1;
            end
          end
          S_ERR: begin
            out_byte  <= 8'hEE;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ntcrack_host_driver.sv
// Directed bench for ntcrack_host_driver with a small cracker model that
// drops your_turn for two cycles after every strobe and serves a password
// table indexed by the number of go pulses since the table was loaded.
module tb_ntcrack_host_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] new_hash_byte;
  logic       store_hash_byte;
  logic       go;
  logic       your_turn = 1'b1;
  logic       match_found;
  logic [7:0] password_byte;

  int n_checks = 0;
  int n_fail   = 0;

  // cracker model state
  int         busy        = 0;
  int         store_total = 0;
  int         go_total    = 0;
  int         overlap_cnt = 0;
  int         go_base     = 0;
  int         pw_k;
  logic [7:0] stored [0:255];
  logic [7:0] pw     [0:31];

  always #5 clk = ~clk;

  ntcrack_host_driver dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_byte         (in_byte),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_byte        (out_byte),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .new_hash_byte   (new_hash_byte),
    .store_hash_byte (store_hash_byte),
    .go              (go),
    .your_turn       (your_turn),
    .match_found     (match_found),
    .password_byte   (password_byte)
  );

  // Cracker model: record strobes, drop your_turn for two cycles per strobe
  always @(posedge clk) begin
    if (store_hash_byte && go) overlap_cnt <= overlap_cnt + 1;
    if (store_hash_byte) begin
      stored[store_total[7:0]] <= new_hash_byte;
      store_total <= store_total + 1;
    end
    if (go) go_total <= go_total + 1;
    if (store_hash_byte || go) begin
      your_turn <= 1'b0;
      busy      <= 2;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end else if (busy == 1) begin
      busy      <= 0;
      your_turn <= 1'b1;
    end
  end

  assign pw_k          = go_total - go_base;
  assign password_byte = (pw_k >= 1 && pw_k <= 32) ? pw[pw_k-1] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_send(input logic [7:0] b);
    int t = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic host_recv(input string tag, input logic [7:0] exp);
    int t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, {24'd0, out_byte}, {24'd0, exp});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_go(input int target);
    int t = 0;
    while ((go_total - go_base) < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("go_count_wait", go_total - go_base, target);
  endtask

  task automatic send_frame(input logic [7:0] first);
    host_send(8'h01);
    for (int i = 0; i < 16; i++) host_send(first + 8'(i));
  endtask

  initial begin
    int s_base;
    reset_n     = 1'b0;
    in_byte     = 8'h00;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    match_found = 1'b0;
    for (int i = 0; i < 32; i++) pw[i] = 8'h00;

    // ---- reset: three cycles low, all outputs quiet ----
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},        32'd0);
    check("rst_out_valid", {31'd0, out_valid},       32'd0);
    check("rst_out_byte",  {24'd0, out_byte},        32'd0);
    check("rst_hash_byte", {24'd0, new_hash_byte},   32'd0);
    check("rst_store",     {31'd0, store_hash_byte}, 32'd0);
    check("rst_go",        {31'd0, go},              32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- load 0x00..0x0F, start, then exhaustion with backpressure ----
    s_base  = store_total;
    go_base = go_total;
    send_frame(8'h00);
    wait_go(1);
    check("load_store_count", store_total - s_base, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("load_byte%0d", i), {24'd0, stored[8'(s_base + i)]}, i);
    check("run_in_ready",  {31'd0, in_ready},  32'd0);
    check("run_out_valid", {31'd0, out_valid}, 32'd0);
    in_byte  = 8'h05;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !out_valid; t++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_byte_c%0d", c),  {24'd0, out_byte},  32'd0);
      check($sformatf("bp_inrdy_c%0d", c), {31'd0, in_ready},  32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_in_ready", {31'd0, in_ready},  32'd1);
    check("bp_go_total",      go_total - go_base, 1);

    // ---- bad counts: 0x00 and 0x81 answer 0xEE without strobes ----
    s_base  = store_total;
    go_base = go_total;
    host_send(8'h00);
    host_recv("err_zero", 8'hEE);
    host_send(8'h81);
    host_recv("err_81", 8'hEE);
    repeat (3) @(negedge clk);
    check("err_no_store", store_total - s_base, 0);
    check("err_no_go",    go_total - go_base,   0);
    check("err_idle",     {31'd0, in_ready},    32'd1);

    // ---- match: length 4, "pass" ----
    pw[0] = 8'd4; pw[1] = 8'h70; pw[2] = 8'h61; pw[3] = 8'h73; pw[4] = 8'h73;
    match_found = 1'b1;
    go_base     = go_total;
    send_frame(8'hA0);
    host_recv("m_flag", 8'h01);
    host_recv("m_len",  8'h04);
    host_recv("m_c0",   8'h70);
    host_recv("m_c1",   8'h61);
    host_recv("m_c2",   8'h73);
    host_recv("m_c3",   8'h73);
    repeat (6) @(negedge clk);
    check("m_go_total", go_total - go_base, 5);
    check("m_idle",     {31'd0, in_ready},  32'd1);

    // ---- match with length 25, clamped to 20 ----
    pw[0] = 8'd25;
    for (int i = 1; i <= 20; i++) pw[i] = 8'h40 + 8'(i);
    go_base = go_total;
    send_frame(8'h10);
    host_recv("cl_flag", 8'h01);
    host_recv("cl_len",  8'd20);
    for (int i = 1; i <= 20; i++)
      host_recv($sformatf("cl_c%0d", i), 8'h40 + 8'(i));
    repeat (6) @(negedge clk);
    check("cl_go_total", go_total - go_base, 21);
    check("cl_idle",     {31'd0, in_ready},  32'd1);

    // ---- match with length 0: no advance ----
    pw[0]   = 8'd0;
    go_base = go_total;
    send_frame(8'h20);
    host_recv("z_flag", 8'h01);
    host_recv("z_len",  8'h00);
    repeat (6) @(negedge clk);
    check("z_go_total",  go_total - go_base, 1);
    check("z_out_valid", {31'd0, out_valid}, 32'd0);
    match_found = 1'b0;

    // ---- reset after 7 of 16 bytes, then a fresh frame ----
    s_base  = store_total;
    go_base = go_total;
    host_send(8'h01);
    for (int i = 0; i < 7; i++) host_send(8'h50 + 8'(i));
    reset_n = 1'b0;
    @(negedge clk);
    check("mr_store_rst", {31'd0, store_hash_byte}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mr_store_after", {31'd0, store_hash_byte}, 32'd0);
    repeat (8) @(negedge clk);
    check("mr_store_count", store_total - s_base, 7);
    check("mr_no_go",       go_total - go_base,   0);
    s_base = store_total;
    send_frame(8'h30);
    wait_go(1);
    check("mr2_store_count", store_total - s_base, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("mr2_byte%0d", i), {24'd0, stored[8'(s_base + i)]}, 32'h30 + i);
    host_recv("mr2_result", 8'h00);
    check("overlap_strobes", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
